// File: rtl/uart_boot_streamer.sv
// rtl/uart_boot_streamer.sv - framed UART boot-image transmitter (STP marker, payload, ON marker)
module uart_boot_streamer #(
    parameter int         CLK_DIV   = 1085,
    parameter int         DATA_BITS = 8,
    parameter int         PARITY    = 0,
    parameter int         STOP_BITS = 1,
    parameter int         GAP_BITS  = 0,
    parameter logic [7:0] STP_BYTE  = 8'h55,
    parameter logic [7:0] ON_BYTE   = 8'hAA,
    parameter int         LEN_W     = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             TX,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] byte_cnt
);
    localparam int            TW        = $clog2(CLK_DIV);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [7:0]    STOP_LAST = 8'(STOP_BITS - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(GAP_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, FIN} xfer_e;
    typedef enum logic [2:0] {F_IDLE, F_START, F_DATA, F_PAR, F_STOP, F_GAP} frame_e;

    xfer_e            x_q;
    frame_e           f_q;
    logic [TW-1:0]    timer_q;
    logic [2:0]       bit_q;
    logic [7:0]       cnt_q;
    logic [7:0]       sh_q;
    logic             par_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt_q;

    logic       bit_end, frame_end, more, hs, launch;
    logic [7:0] launch_byte;

    assign bit_end   = (timer_q == BIT_LAST);
    assign frame_end = bit_end && (((f_q == F_STOP) && (cnt_q == STOP_LAST) && (GAP_BITS == 0)) ||
                                   ((f_q == F_GAP) && (cnt_q == GAP_LAST)));
    assign more      = (byte_cnt_q != len_q);
    // Accepting in the last cycle of a frame lets the next start bit follow with no idle cycle.
    assign s_ready   = ((x_q == HDR) && frame_end && (len_q != '0)) ||
                       ((x_q == PAY) && more && ((f_q == F_IDLE) || frame_end));
    assign hs        = s_valid && s_ready;
    assign launch    = hs || ((x_q == IDLE) && start) ||
                       (frame_end && (((x_q == HDR) && (len_q == '0)) || ((x_q == PAY) && !more)));
    assign launch_byte = (x_q == IDLE) ? STP_BYTE : (hs ? s_data : ON_BYTE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            x_q        <= IDLE;
            f_q        <= F_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                f_q     <= F_START;
                timer_q <= '0;
                tx_q    <= 1'b0;
                sh_q    <= launch_byte & DATA_MASK;
                par_q   <= (^(launch_byte & DATA_MASK)) ^ (PARITY == 1);
            end else if (f_q != F_IDLE) begin
                timer_q <= bit_end ? '0 : timer_q + TW'(1);
                if (bit_end) begin
                    case (f_q)
                        F_START: begin
                            f_q   <= F_DATA;
                            bit_q <= '0;
                            tx_q  <= sh_q[0];
                        end
                        F_DATA: begin
                            if (bit_q == DATA_LAST) begin
                                cnt_q <= '0;
                                if (PARITY != 0) begin
                                    f_q  <= F_PAR;
                                    tx_q <= par_q;
                                end else begin
                                    f_q  <= F_STOP;
                                    tx_q <= 1'b1;
                                end
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                sh_q  <= sh_q >> 1;
                                tx_q  <= sh_q[1];
                            end
                        end
                        F_PAR: begin
                            f_q   <= F_STOP;
                            cnt_q <= '0;
                            tx_q  <= 1'b1;
                        end
                        F_STOP: begin
                            if (cnt_q == STOP_LAST) begin
                                cnt_q <= '0;
                                f_q   <= (GAP_BITS != 0) ? F_GAP : F_IDLE;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        F_GAP: begin
                            if (cnt_q == GAP_LAST) f_q <= F_IDLE;
                            else cnt_q <= cnt_q + 8'd1;
                        end
                        default: f_q <= F_IDLE;
                    endcase
                end
            end

            if (hs) byte_cnt_q <= byte_cnt_q + 1'b1;
            case (x_q)
                IDLE: if (start) begin
                    len_q      <= len;
                    byte_cnt_q <= '0;
                    busy_q     <= 1'b1;
                    x_q        <= HDR;
                end
                HDR: if (frame_end) x_q <= (len_q != '0) ? PAY : TRL;
                PAY: if (frame_end && !more) x_q <= TRL;
                TRL: if (frame_end) begin
                    x_q    <= FIN;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                FIN: x_q <= IDLE;
                default: x_q <= IDLE;
            endcase
        end
    end

    assign TX       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_cnt = byte_cnt_q;
endmodule

// File: doc/uart_boot_streamer.md
Name: uart_boot_streamer

Overview:
Parametrised UART boot-image transmitter. It sends a framed byte stream: one STP marker byte, then N payload bytes, then one ON marker byte. It is the synthesizable successor of the bench-side bootloader UART driver, with configurable baud divider, data bits, parity, stop bits and inter-frame gap. Payload arrives over a valid/ready byte interface. Its TX output feeds the system RX pin, either in the cv32e40p system bench or in an on-FPGA self-loader.

Parameters:
CLK_DIV, 1085, clock cycles per UART bit (125 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2
GAP_BITS, 0, idle bit-times inserted after every frame's stop bits
STP_BYTE, 8'h55, header marker byte
ON_BYTE, 8'hAA, trailer marker byte
LEN_W, 16, width of the payload length field

Ports:
Clk  input  1  system clock
Rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a transfer; honoured only when busy=0
len  input  LEN_W  payload byte count, sampled when start is honoured
s_data  input  8  payload byte; only bits [DATA_BITS-1:0] are transmitted
s_valid  input  1  s_data is valid
s_ready  output  1  block accepts s_data this cycle
TX  output  1  UART serial line, idle high
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the trailer frame completes
byte_cnt  output  LEN_W  count of payload bytes accepted in the current transfer

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high (Rst).
- Reset values: TX=1, busy=0, done=0, s_ready=0, byte_cnt=0. Both FSMs return to IDLE.
- Reset asserted mid-frame forces TX=1 immediately (asynchronously). No partial frame resumes after reset releases.
- Transfer FSM has five states: IDLE, HDR, PAY, TRL, FIN.
  - IDLE: on start, latch len, clear byte_cnt, set busy, go to HDR.
  - HDR: launch an STP_BYTE frame. On frame end, go to PAY if len>0, otherwise go to TRL.
  - PAY: while the frame engine is idle, s_ready = s_valid-independent 1. On s_valid && s_ready, capture s_data, increment byte_cnt and launch a frame. s_ready is low while a frame is in flight.
  - PAY exit: when byte_cnt==len and the last frame has ended, go to TRL.
  - PAY stall: if s_valid stays low, TX holds 1 indefinitely; there is no timeout.
  - TRL: launch an ON_BYTE frame. On frame end, go to FIN.
  - FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- start while busy=1 is ignored and len is not re-sampled. start and the FIN cycle coinciding: start is ignored.
- Frame engine states: F_IDLE, F_START, F_DATA, F_PAR, F_STOP, F_GAP.
  - The bit timer counts 0..CLK_DIV-1. Each bit lasts exactly CLK_DIV cycles.
  - Data is sent LSB first, DATA_BITS bits.
  - F_PAR is skipped when PARITY=0. Even parity makes the total count of ones (data + parity) even; odd parity makes it odd.
  - F_STOP lasts STOP_BITS bit-times. F_GAP lasts GAP_BITS bit-times (skipped if 0). TX=1 in both.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS + GAP_BITS) * CLK_DIV cycles.
- Latency:
  - start sampled at cycle 0 -> TX falls (start bit) at cycle 1.
  - Payload handshake at cycle k -> TX falls at cycle k+1.
  - Back-to-back frames: the next start bit follows the last stop/gap bit with no extra idle cycle, provided s_valid is high.
- Marker bytes are also truncated to DATA_BITS.
- byte_cnt holds its final value after done until the next honoured start.
- len = max value (2^LEN_W − 1) is legal. There is no wrap, since the count stops at len.
- TX is registered (no combinational glitches).

Test Plan:
1. Reset check: CLK_DIV=4, default parity. Assert Rst -> TX=1, busy=0, s_ready=0, byte_cnt=0. Pulse start with len=0 -> TX carries 0x55 then 0xAA, LSB first, each bit 4 cycles. Frames are 40 cycles each. done pulses at cycle 81, where busy also falls.
2. Payload stream: len=3, bytes 0x01, 0x80, 0xFF with s_valid held high -> five contiguous frames 55, 01, 80, FF, AA with no idle gaps. byte_cnt ends at 3. s_ready pulses exactly 3 times.
3. Parity and stop bits: PARITY=2, STOP_BITS=2, DATA_BITS=7, byte 0x83 -> 7 data bits 1100000, parity bit 0, two stop bits; frame is 11 bit-times. With PARITY=1 the parity bit is 1.
4. Stall and gap: GAP_BITS=2, len=2. Drop s_valid for 100 cycles after the first payload byte -> TX stays 1 throughout, s_ready stays high. Transfer resumes on s_valid. Every frame is followed by exactly 8 idle cycles (2 bit-times at CLK_DIV=4).
5. Start ignored while busy: pulse start with len=5 during the HDR frame of a len=1 transfer -> only one payload byte is sent, and done pulses once.
6. Reset mid-transfer: assert Rst during the data bits of payload byte 2 -> TX=1 asynchronously, busy=0, byte_cnt=0. A new start after reset produces a clean STP header.
